// File: rtl/p65_status_reg.sv
// 65C816 processor status (P) and emulation (E) flag register with ALU feedback.
// Optional STATUS_SNAPSHOT_EN adds an interrupt-entry {E,P} snapshot with restore.
module p65_status_reg #(
   parameter logic [7:0] RESET_P = 8'h34,
   parameter logic       RESET_E = 1'b1
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       CE,
   input  logic       ALU_CO,
   input  logic       ALU_VO,
   input  logic       ALU_SO,
   input  logic       ALU_ZO,
   input  logic [3:0] FLAG_LD,
   input  logic       REP,
   input  logic       SEP,
   input  logic [7:0] IMM,
   input  logic       PLP,
   input  logic [7:0] DIN,
   input  logic       XCE,
   input  logic       INT_ENTRY,
   input  logic       BRK_IN,
`ifdef STATUS_SNAPSHOT_EN
   input  logic       RESTORE_SNAP,
   output logic       SNAP_VALID,
`endif
   output logic [7:0] P_OUT,
   output logic [7:0] P_PUSH,
   output logic       E_OUT,
   output logic       W16_A,
   output logic       W16_X,
   output logic       BCD_OUT,
   output logic       CI_OUT,
   output logic       IDX_HI_CLR
);

   logic [7:0] p_q;
   logic [7:0] p_d;
   logic       e_q;
   logic       e_d;
   logic       idx_clr_q;
   logic       idx_clr_d;
   logic [7:0] p_plp_s;
   logic [7:0] p_rep_s;
   logic [7:0] p_sep_s;
   logic [7:0] p_ld_s;
   logic [7:0] p_xce_s;
   logic       e_xce_s;
   logic       restore_s;

`ifdef STATUS_SNAPSHOT_EN
   logic [8:0] snap_q;
   logic       snap_valid_q;
`endif

   // Next-state P/E: ordered command pipeline, then emulation forcing and interrupt override.
   always_comb begin
      p_plp_s   = PLP ? DIN : p_q;
      p_rep_s   = REP ? (p_plp_s & ~IMM) : p_plp_s;
      p_sep_s   = SEP ? (p_rep_s | IMM) : p_rep_s;
      p_ld_s    = p_sep_s;
      p_ld_s[7] = FLAG_LD[3] ? ALU_SO : p_sep_s[7];
      p_ld_s[6] = FLAG_LD[2] ? ALU_VO : p_sep_s[6];
      p_ld_s[1] = FLAG_LD[1] ? ALU_ZO : p_sep_s[1];
      p_ld_s[0] = FLAG_LD[0] ? ALU_CO : p_sep_s[0];
      // XCE swaps against the pre-edge register values, not the staged ones
      p_xce_s    = p_ld_s;
      p_xce_s[0] = XCE ? e_q : p_ld_s[0];
      e_xce_s    = XCE ? p_q[0] : e_q;
`ifdef STATUS_SNAPSHOT_EN
      restore_s = RESTORE_SNAP & snap_valid_q;
`else
      restore_s = 1'b0;
`endif
      if (restore_s) begin
`ifdef STATUS_SNAPSHOT_EN
         p_d = snap_q[7:0];
         e_d = snap_q[8];
`else
         p_d = p_xce_s;
         e_d = e_xce_s;
`endif
      end else begin
         p_d = p_xce_s;
         e_d = e_xce_s;
      end
      if (e_d) begin
         p_d[5:4] = 2'b11;
      end else begin
         p_d[5:4] = p_d[5:4];
      end
      if (INT_ENTRY) begin
         p_d[2] = 1'b1;
         p_d[3] = 1'b0;
      end else begin
         p_d[3:2] = p_d[3:2];
      end
      idx_clr_d = ~p_q[4] & p_d[4];
   end

   // State register: P, E and the index-high clear pulse advance only on CE.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         p_q       <= RESET_P;
         e_q       <= RESET_E;
         idx_clr_q <= 1'b0;
      end else if (CE) begin
         p_q       <= p_d;
         e_q       <= e_d;
         idx_clr_q <= idx_clr_d;
      end else begin
         p_q       <= p_q;
         e_q       <= e_q;
         idx_clr_q <= idx_clr_q;
      end
   end

`ifdef STATUS_SNAPSHOT_EN
   // Snapshot register: capture on interrupt entry, invalidate once restored.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         snap_q       <= 9'h000;
         snap_valid_q <= 1'b0;
      end else if (CE && INT_ENTRY) begin
         snap_q       <= {e_q, p_q};
         snap_valid_q <= 1'b1;
      end else if (CE && restore_s) begin
         snap_q       <= snap_q;
         snap_valid_q <= 1'b0;
      end else begin
         snap_q       <= snap_q;
         snap_valid_q <= snap_valid_q;
      end
   end

   assign SNAP_VALID = snap_valid_q;
`endif

   assign P_OUT      = p_q;
   assign E_OUT      = e_q;
   assign P_PUSH     = e_q ? {p_q[7:6], 1'b1, BRK_IN, p_q[3:0]} : p_q;
   assign W16_A      = ~p_q[5] & ~e_q;
   assign W16_X      = ~p_q[4] & ~e_q;
   assign BCD_OUT    = p_q[3];
   assign CI_OUT     = p_q[0];
   assign IDX_HI_CLR = idx_clr_q;

endmodule

// File: tb/tb_p65_status_reg.sv
// Scoreboard bench for p65_status_reg: directed vectors push expected state, a monitor pops and checks.
module tb_p65_status_reg;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic       CE;
   logic       ALU_CO, ALU_VO, ALU_SO, ALU_ZO;
   logic [3:0] FLAG_LD;
   logic       REP, SEP, PLP, XCE, INT_ENTRY, BRK_IN;
   logic [7:0] IMM, DIN;
   logic [7:0] P_OUT, P_PUSH;
   logic       E_OUT, W16_A, W16_X, BCD_OUT, CI_OUT, IDX_HI_CLR;

   typedef struct packed {
      logic [7:0] p;
      logic       e;
      logic       idx;
      logic       brk;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   p65_status_reg dut (
      .CLK(CLK), .RST_N(RST_N), .CE(CE),
      .ALU_CO(ALU_CO), .ALU_VO(ALU_VO), .ALU_SO(ALU_SO), .ALU_ZO(ALU_ZO),
      .FLAG_LD(FLAG_LD), .REP(REP), .SEP(SEP), .IMM(IMM), .PLP(PLP), .DIN(DIN),
      .XCE(XCE), .INT_ENTRY(INT_ENTRY), .BRK_IN(BRK_IN),
      .P_OUT(P_OUT), .P_PUSH(P_PUSH), .E_OUT(E_OUT), .W16_A(W16_A), .W16_X(W16_X),
      .BCD_OUT(BCD_OUT), .CI_OUT(CI_OUT), .IDX_HI_CLR(IDX_HI_CLR)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: one expected record per sampled cycle, checked 1 time unit after the edge.
   initial begin
      exp_t x;
      logic [7:0] push_s;
      forever begin
         @(posedge CLK);
         #1;
         if (sb.size() != 0) begin
            x = sb.pop_front();
            push_s = x.e ? {x.p[7:6], 1'b1, x.brk, x.p[3:0]} : x.p;
            chk("P_OUT", P_OUT, x.p);
            chk("E_OUT", {7'd0, E_OUT}, {7'd0, x.e});
            chk("IDX_HI_CLR", {7'd0, IDX_HI_CLR}, {7'd0, x.idx});
            chk("W16_A", {7'd0, W16_A}, {7'd0, ~x.p[5] & ~x.e});
            chk("W16_X", {7'd0, W16_X}, {7'd0, ~x.p[4] & ~x.e});
            chk("BCD_OUT", {7'd0, BCD_OUT}, {7'd0, x.p[3]});
            chk("CI_OUT", {7'd0, CI_OUT}, {7'd0, x.p[0]});
            chk("P_PUSH", P_PUSH, push_s);
         end
      end
   end

   task automatic idle_inputs();
      CE = 1'b0; PLP = 1'b0; REP = 1'b0; SEP = 1'b0; XCE = 1'b0; INT_ENTRY = 1'b0;
      IMM = 8'h00; DIN = 8'h00; FLAG_LD = 4'h0;
      {ALU_SO, ALU_VO, ALU_ZO, ALU_CO} = 4'h0; BRK_IN = 1'b1;
   endtask

   // alu = {SO,VO,ZO,CO}
   task automatic step(input logic ce, input logic plp, input logic rep, input logic sep,
                       input logic xce, input logic intr, input logic [7:0] imm,
                       input logic [7:0] din, input logic [3:0] ld, input logic [3:0] alu,
                       input logic brk, input logic [7:0] ep, input logic ee, input logic eidx);
      exp_t x;
      @(negedge CLK);
      CE = ce; PLP = plp; REP = rep; SEP = sep; XCE = xce; INT_ENTRY = intr;
      IMM = imm; DIN = din; FLAG_LD = ld; {ALU_SO, ALU_VO, ALU_ZO, ALU_CO} = alu; BRK_IN = brk;
      x.p = ep; x.e = ee; x.idx = eidx; x.brk = brk;
      sb.push_back(x);
   endtask

   task automatic reset_step();
      exp_t x;
      @(negedge CLK);
      idle_inputs();
      RST_N = 1'b0;
      x.p = 8'h34; x.e = 1'b1; x.idx = 1'b0; x.brk = 1'b1;
      sb.push_back(x);
      @(negedge CLK);
      RST_N = 1'b1;
   endtask

   initial begin
      int wait_cnt;
      RST_N = 1'b0;
      idle_inputs();
      repeat (2) @(posedge CLK);
      reset_step();
      //    ce plp rep sep xce int imm    din    ld       alu      brk  P      E     idx
      step(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 4'b0000, 4'b0000, 1, 8'h34, 1'b1, 1'b0);
      step(1, 0, 1, 0, 0, 0, 8'h01, 8'h00, 4'b0000, 4'b0000, 1, 8'h34, 1'b1, 1'b0);
      step(1, 0, 0, 0, 1, 0, 8'h00, 8'h00, 4'b0000, 4'b0000, 1, 8'h35, 1'b0, 1'b0);
      step(1, 0, 1, 0, 0, 0, 8'h30, 8'h00, 4'b0000, 4'b0000, 1, 8'h05, 1'b0, 1'b0);
      step(1, 0, 0, 1, 0, 0, 8'h10, 8'h00, 4'b0000, 4'b0000, 1, 8'h15, 1'b0, 1'b1);
      step(0, 0, 0, 1, 0, 0, 8'h20, 8'h00, 4'b0000, 4'b0000, 1, 8'h15, 1'b0, 1'b1);
      step(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 4'b0000, 4'b0000, 1, 8'h15, 1'b0, 1'b0);
      step(1, 0, 1, 0, 0, 0, 8'h80, 8'h00, 4'b1011, 4'b1100, 1, 8'h94, 1'b0, 1'b0);
      step(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 4'b0110, 4'b0110, 1, 8'hD6, 1'b0, 1'b0);
      step(1, 0, 1, 0, 0, 0, 8'h11, 8'h00, 4'b0000, 4'b0000, 1, 8'hC6, 1'b0, 1'b0);
      step(1, 0, 0, 1, 0, 0, 8'h01, 8'h00, 4'b0000, 4'b0000, 1, 8'hC7, 1'b0, 1'b0);
      step(1, 0, 0, 0, 1, 0, 8'h00, 8'h00, 4'b0000, 4'b0000, 0, 8'hF6, 1'b1, 1'b1);
      step(1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 4'b0000, 4'b0000, 1, 8'h30, 1'b1, 1'b0);
      step(1, 0, 0, 1, 0, 0, 8'h08, 8'h00, 4'b0000, 4'b0000, 1, 8'h38, 1'b1, 1'b0);
      step(1, 0, 0, 1, 0, 1, 8'h01, 8'h00, 4'b0000, 4'b0000, 1, 8'h35, 1'b1, 1'b0);
      step(0, 1, 1, 0, 1, 1, 8'hFF, 8'h00, 4'b1111, 4'b1111, 1, 8'h35, 1'b1, 1'b0);
      step(1, 1, 0, 0, 1, 0, 8'h00, 8'hFF, 4'b0000, 4'b0000, 1, 8'hFF, 1'b1, 1'b0);
      step(1, 0, 1, 1, 0, 0, 8'h05, 8'h00, 4'b0000, 4'b0000, 1, 8'hFF, 1'b1, 1'b0);
      step(1, 0, 1, 0, 0, 0, 8'h0A, 8'h00, 4'b0000, 4'b0000, 1, 8'hF5, 1'b1, 1'b0);
      step(1, 0, 1, 0, 0, 0, 8'h01, 8'h00, 4'b0000, 4'b0000, 1, 8'hF4, 1'b1, 1'b0);
      step(1, 0, 0, 0, 1, 0, 8'h00, 8'h00, 4'b0000, 4'b0000, 1, 8'hF5, 1'b0, 1'b0);
      step(1, 0, 1, 0, 0, 0, 8'h30, 8'h00, 4'b0000, 4'b0000, 1, 8'hC5, 1'b0, 1'b0);
      step(1, 1, 0, 0, 0, 0, 8'h00, 8'h10, 4'b0000, 4'b0000, 1, 8'h10, 1'b0, 1'b1);
      step(1, 1, 0, 0, 0, 1, 8'h00, 8'h08, 4'b0000, 4'b0000, 1, 8'h04, 1'b0, 1'b0);
      reset_step();
      step(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 4'b0000, 4'b0000, 1, 8'h34, 1'b1, 1'b0);
      @(negedge CLK);
      idle_inputs();
      wait_cnt = 0;
      while (sb.size() != 0 && wait_cnt < 20) begin
         @(negedge CLK);
         wait_cnt++;
      end
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d records left, expected 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
